alu_cmd_driver: RTL and testbench

- Synthesizable initiator for the 8-input / 8-output ALU_test block; turns the hand-written stimulus sequence into hardware.
- Accepts one 8-bit command word over a valid/ready handshake.
- For each command it pulses the ALU reset, presents the word on IN7..IN0, holds it for a fixed number of cycles, then captures OUT7..OUT0.
- Returns the captured result, paired with its originating command, over a second valid/ready handshake. Sits between a command source (host FSM or bench) and the ALU.

---
 rtl/alu_cmd_driver_if.sv | 22 ++
 rtl/alu_cmd_driver.sv | 123 ++++++++++++
 tb/tb_alu_cmd_driver.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_driver_if.sv
// Command/response handshake bundle between a command source and alu_cmd_driver.
// cmd_*: command word in (valid/ready). rsp_*: captured ALU result plus its command out.
// slave = driver side, master = command source / consumer side.
interface alu_cmd_driver_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [7:0] rsp_cmd;

  modport slave (
    input  cmd_valid, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_cmd
  );

  modport master (
    output cmd_valid, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_cmd
  );
endinterface

// File: rtl/alu_cmd_driver.sv
// Purpose: per command, pulse the ALU reset, present the word on IN7..IN0, hold it, capture OUT7..OUT0.
// Latency: accept at edge E -> alu_out sampled at E+RST_CYCLES+HOLD_CYCLES; rsp_valid from that edge on.
// Backpressure: cmd_ready low outside IDLE; response held stable until rsp_ready.
// Ports: CLK, rst (async, active-low), bus (cmd/rsp handshake), alu_rst/alu_in/alu_out to the ALU,
//        busy (not IDLE), cmd_count (completed responses, saturating).
module alu_cmd_driver #(
  parameter int unsigned RST_CYCLES  = 1,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic                CLK,
  input  logic                rst,
  alu_cmd_driver_if.slave     bus,
  output logic                alu_rst,
  output logic [7:0]          alu_in,
  input  logic [7:0]          alu_out,
  output logic                busy,
  output logic [15:0]         cmd_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ALU_RST = 2'd1,
    HOLD    = 2'd2,
    RESP    = 2'd3
  } state_t;

  // Counters are loaded with N-1 so the phase lasts exactly N cycles.
  localparam logic [3:0] RST_LD  = 4'(RST_CYCLES - 1);
  localparam logic [3:0] HOLD_LD = 4'(HOLD_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [7:0]  cmd_q;
  logic        cmd_ready_q;
  logic        alu_rst_q;
  logic [7:0]  alu_in_q;
  logic        rsp_valid_q;
  logic [7:0]  rsp_data_q;
  logic [7:0]  rsp_cmd_q;
  logic        busy_q;
  logic [15:0] cmd_count_q;

  // Every output is written together with the state transition that implies it,
  // so outputs are registered and line up with the state they belong to.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      cmd_q       <= 8'h00;
      cmd_ready_q <= 1'b1;
      alu_rst_q   <= 1'b0;
      alu_in_q    <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_cmd_q   <= 8'h00;
      busy_q      <= 1'b0;
      cmd_count_q <= 16'h0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            cmd_q       <= bus.cmd_data;
            cnt_q       <= RST_LD;
            state_q     <= ALU_RST;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            alu_rst_q   <= 1'b1;
            alu_in_q    <= bus.cmd_data;
          end
        end
        ALU_RST: begin
          if (cnt_q == 4'd0) begin
            cnt_q     <= HOLD_LD;
            state_q   <= HOLD;
            alu_rst_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        HOLD: begin
          if (cnt_q == 4'd0) begin
            rsp_data_q  <= alu_out;
            rsp_cmd_q   <= cmd_q;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (cmd_count_q != 16'hFFFF) begin
              cmd_count_q <= cmd_count_q + 16'd1;
            end
            alu_in_q    <= 8'h00;
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          alu_rst_q   <= 1'b0;
          alu_in_q    <= 8'h00;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_cmd   = rsp_cmd_q;
  assign alu_rst       = alu_rst_q;
  assign alu_in        = alu_in_q;
  assign busy          = busy_q;
  assign cmd_count     = cmd_count_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver: default-parameter instance plus a RST_CYCLES=3/HOLD_CYCLES=4 instance.
// Each instance drives its own small ALU lookup model; sel chooses which one the stimulus talks to.
// Expected values are hand-computed from the ALU table and the cycle timing.
module tb_alu_cmd_driver;

  logic        CLK;
  logic        rst;
  logic        sel;
  logic        cmd_valid;
  logic [7:0]  cmd_data;
  logic        rsp_ready;

  alu_cmd_driver_if if1 ();
  alu_cmd_driver_if if2 ();

  logic        alu_rst1, alu_rst2;
  logic [7:0]  alu_in1, alu_in2;
  logic [7:0]  alu_out1, alu_out2;
  logic        busy1, busy2;
  logic [15:0] cmd_count1, cmd_count2;

  int tests_run;
  int tests_failed;

  // ALU stand-in: fixed lookup; drives EE while its reset is high so a capture
  // taken during the reset phase is visible.
  function automatic logic [7:0] alu_f(input logic r, input logic [7:0] a);
    logic [7:0] y;
    y = a ^ 8'hFF;
    if (r) y = 8'hEE;
    else begin
      case (a)
        8'h09:   y = 8'h5A;
        8'h0A:   y = 8'hA5;
        8'h12:   y = 8'h3C;
        8'h1B:   y = 8'hC3;
        default: y = a ^ 8'hFF;
      endcase
    end
    return y;
  endfunction

  assign alu_out1 = alu_f(alu_rst1, alu_in1);
  assign alu_out2 = alu_f(alu_rst2, alu_in2);

  assign if1.cmd_valid = cmd_valid & ~sel;
  assign if2.cmd_valid = cmd_valid & sel;
  assign if1.cmd_data  = cmd_data;
  assign if2.cmd_data  = cmd_data;
  assign if1.rsp_ready = rsp_ready;
  assign if2.rsp_ready = rsp_ready;

  alu_cmd_driver u_dut1 (
    .CLK(CLK), .rst(rst), .bus(if1),
    .alu_rst(alu_rst1), .alu_in(alu_in1), .alu_out(alu_out1),
    .busy(busy1), .cmd_count(cmd_count1)
  );

  alu_cmd_driver #(.RST_CYCLES(3), .HOLD_CYCLES(4)) u_dut2 (
    .CLK(CLK), .rst(rst), .bus(if2),
    .alu_rst(alu_rst2), .alu_in(alu_in2), .alu_out(alu_out2),
    .busy(busy2), .cmd_count(cmd_count2)
  );

  logic        obs_cmd_ready, obs_rsp_valid, obs_alu_rst, obs_busy;
  logic [7:0]  obs_rsp_data, obs_rsp_cmd, obs_alu_in;
  logic [15:0] obs_cmd_count;

  assign obs_cmd_ready = sel ? if2.cmd_ready : if1.cmd_ready;
  assign obs_rsp_valid = sel ? if2.rsp_valid : if1.rsp_valid;
  assign obs_rsp_data  = sel ? if2.rsp_data  : if1.rsp_data;
  assign obs_rsp_cmd   = sel ? if2.rsp_cmd   : if1.rsp_cmd;
  assign obs_alu_rst   = sel ? alu_rst2      : alu_rst1;
  assign obs_alu_in    = sel ? alu_in2       : alu_in1;
  assign obs_busy      = sel ? busy2         : busy1;
  assign obs_cmd_count = sel ? cmd_count2    : cmd_count1;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Issue one command from a negedge with rsp_ready=1 and follow it through the handshake.
  task automatic run_cmd(input logic [7:0] c, input logic [7:0] exp_d, input int exp_rst,
                         input int exp_lat, input logic [15:0] exp_cnt, output time t_vld);
    int  n, nrst, nin;
    bit  seen;
    n = 0; nrst = 0; nin = 0; seen = 0; t_vld = 0;
    check("cmd_ready_idle", 32'(obs_cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_data  = c;
    @(posedge CLK);
    #1 cmd_valid = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge CLK);
      if (obs_rsp_valid) begin
        seen  = 1;
        n     = i;
        t_vld = $time;
      end else begin
        if (obs_alu_rst) nrst++;
        if (obs_alu_in == c) nin++;
      end
    end
    check("rsp_timeout", 32'(seen), 32'd1);
    check("alu_rst_cycles", 32'(nrst), 32'(exp_rst));
    check("alu_in_cycles", 32'(nin), 32'(exp_lat));
    check("rsp_latency", 32'(n - 1), 32'(exp_lat));
    check("rsp_data", 32'(obs_rsp_data), 32'(exp_d));
    check("rsp_cmd", 32'(obs_rsp_cmd), 32'(c));
    check("cmd_ready_resp", 32'(obs_cmd_ready), 32'd0);
    @(negedge CLK);
    check("rsp_valid_drop", 32'(obs_rsp_valid), 32'd0);
    check("cmd_count", 32'(obs_cmd_count), 32'(exp_cnt));
    check("alu_in_idle", 32'(obs_alu_in), 32'd0);
    check("busy_idle", 32'(obs_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", tests_run);
    $fatal(1, "watchdog");
  end

  initial begin
    time t [4];
    time tt;
    bit  bad;
    tests_run = 0;
    tests_failed = 0;
    sel = 1'b0;
    rst = 1'b1;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_data  = 8'h33;

    // 1. Reset asserted mid-cycle must act before the next edge.
    @(posedge CLK);
    #3 rst = 1'b0;
    #1;
    check("rst_async_busy", 32'(busy1), 32'd0);
    check("rst_async_ready", 32'(if1.cmd_ready), 32'd1);
    check("rst_async_alu_rst", 32'(alu_rst1), 32'd0);
    check("rst_async_alu_in", 32'(alu_in1), 32'd0);
    check("rst_async_rsp_valid", 32'(if1.rsp_valid), 32'd0);
    check("rst_async_count", 32'(cmd_count1), 32'd0);
    check("rst_async_rsp_data", 32'(if1.rsp_data), 32'd0);
    check("rst_async_rsp_cmd", 32'(if1.rsp_cmd), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'($urandom);
      cmd_data  = 8'($urandom);
      rsp_ready = 1'($urandom);
      @(negedge CLK);
      check("rst_hold_busy", 32'(busy1), 32'd0);
      check("rst_hold_ready", 32'(if1.cmd_ready), 32'd1);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    rst = 1'b1;
    @(negedge CLK);
    check("post_rst_busy", 32'(busy1), 32'd0);

    // 2. Single command.
    run_cmd(8'h09, 8'h5A, 1, 3, 16'd1, tt);

    // 3. Back-pressure with a second command waiting.
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_data  = 8'h0A;
    @(posedge CLK);
    #1 cmd_valid = 1'b0;
    repeat (4) @(negedge CLK);
    check("bp_valid", 32'(if1.rsp_valid), 32'd1);
    cmd_valid = 1'b1;
    cmd_data  = 8'h12;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      check("bp_hold_valid", 32'(if1.rsp_valid), 32'd1);
      check("bp_hold_data", 32'(if1.rsp_data), 32'hA5);
      check("bp_hold_cmd", 32'(if1.rsp_cmd), 32'h0A);
      check("bp_hold_ready", 32'(if1.cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge CLK);
    check("bp_release_valid", 32'(if1.rsp_valid), 32'd0);
    check("bp_release_ready", 32'(if1.cmd_ready), 32'd1);
    check("bp_keep_cmd", 32'(if1.rsp_cmd), 32'h0A);
    check("bp_count", 32'(cmd_count1), 32'd2);
    run_cmd(8'h12, 8'h3C, 1, 3, 16'd3, tt);

    // 4. Back-to-back stream after a fresh reset.
    rst = 1'b0;
    @(negedge CLK);
    rst = 1'b1;
    check("b2b_count_clr", 32'(cmd_count1), 32'd0);
    run_cmd(8'h09, 8'h5A, 1, 3, 16'd1, t[0]);
    run_cmd(8'h0A, 8'hA5, 1, 3, 16'd2, t[1]);
    run_cmd(8'h12, 8'h3C, 1, 3, 16'd3, t[2]);
    run_cmd(8'h1B, 8'hC3, 1, 3, 16'd4, t[3]);
    for (int i = 1; i < 4; i++) check("b2b_spacing", 32'(t[i] - t[i-1]), 32'd50);

    // 5. Reset during HOLD drops the command.
    cmd_valid = 1'b1;
    cmd_data  = 8'h1B;
    @(posedge CLK);
    #1 cmd_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("mid_in_hold", 32'(alu_in1), 32'h1B);
    #2 rst = 1'b0;
    #1;
    check("mid_async_busy", 32'(busy1), 32'd0);
    check("mid_async_alu_in", 32'(alu_in1), 32'd0);
    check("mid_async_ready", 32'(if1.cmd_ready), 32'd1);
    @(negedge CLK);
    rst = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge CLK);
      if (if1.rsp_valid || busy1) bad = 1;
    end
    check("mid_no_rsp", 32'(bad), 32'd0);
    check("mid_count", 32'(cmd_count1), 32'd0);
    check("mid_ready", 32'(if1.cmd_ready), 32'd1);

    // 6. Non-default timing and count saturation.
    sel = 1'b1;
    run_cmd(8'h09, 8'h5A, 3, 7, 16'd1, tt);
    force u_dut2.cmd_count_q = 16'hFFFF;
    #1 release u_dut2.cmd_count_q;
    check("sat_preload", 32'(cmd_count2), 32'hFFFF);
    run_cmd(8'h0A, 8'hA5, 3, 7, 16'hFFFF, tt);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
